// File: rtl/smpl_trigger_capture_if.sv
// Readout handshake between the trigger capture stage and the sample renderer.
// The capture stage is the master: it offers a frame and returns one word per request.
interface smpl_trigger_capture_if;
  logic       smpl_avail;
  logic       smpl_req;
  logic [9:0] smpl;

  modport master (output smpl_avail, output smpl, input smpl_req);
  modport slave  (input smpl_avail, input smpl, output smpl_req);
endinterface

// File: rtl/smpl_trigger_capture.sv
// Triggered sample capture: circular buffer of ADC samples, level or timeout trigger,
// N-sample frame centred PRE samples after its start, streamed out oldest first.
module smpl_trigger_capture #(
  parameter int N    = 64,
  parameter int PRE  = 16,
  parameter int AUTO = 4096
) (
  input  logic                   clkSmpl,
  input  logic                   n_reset,
  input  logic                   adc_valid,
  input  logic [9:0]             adc,
  input  logic [9:0]             trig_level,
  input  logic                   trig_fall,
  input  logic                   trig_auto,
  output logic                   auto_trig,
  smpl_trigger_capture_if.master smpl_bus
);

  // state    | meaning
  // S_FILL   | collecting PRE samples of pre-trigger history
  // S_ARM    | waiting for level crossing or timeout
  // S_POST   | collecting the post-trigger part of the frame
  // S_READY  | frame frozen, streaming words on request
  typedef enum logic [1:0] {S_FILL, S_ARM, S_POST, S_READY} state_t;

  localparam int AW = $clog2(N);
  localparam int RW = AW + 1;
  localparam int TW = (AUTO > 1) ? $clog2(AUTO) : 1;

  localparam logic [AW-1:0] ONE_A     = AW'(1);
  localparam logic [AW-1:0] PRE_LAST  = AW'(PRE - 1);
  localparam logic [AW-1:0] PRE_OFS   = AW'(PRE);
  localparam logic [AW-1:0] PCNT_INIT = AW'(N - PRE - 1);
  localparam logic [RW-1:0] RCNT_INIT = RW'(N);
  localparam logic [RW-1:0] ONE_R     = RW'(1);
  localparam logic [TW-1:0] ONE_T     = TW'(1);
  localparam logic [TW-1:0] TCNT_LAST = TW'(AUTO - 1);

  state_t        state_q, state_d;
  logic [9:0]    mem [N];
  logic [AW-1:0] wp_q, rp_q, ta_q, fcnt_q, pcnt_q;
  logic [RW-1:0] rcnt_q;
  logic [TW-1:0] tcnt_q;
  logic [9:0]    prev_q, smpl_q;
  logic          avail_q, auto_q;

  logic accept, lvl_hit, time_hit;
  logic fill_done, trig_ev, force_ev, post_done, read_en, read_last;

  assign accept   = adc_valid && (state_q != S_READY);
  assign lvl_hit  = trig_fall ? ((prev_q > trig_level) && (adc <= trig_level))
                              : ((prev_q < trig_level) && (adc >= trig_level));
  assign time_hit = trig_auto && (tcnt_q == TCNT_LAST);

  always_ff @(posedge clkSmpl or negedge n_reset) begin
    if (!n_reset) state_q <= S_FILL;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    fill_done = 1'b0;
    trig_ev   = 1'b0;
    force_ev  = 1'b0;
    post_done = 1'b0;
    read_en   = 1'b0;
    read_last = 1'b0;
    case (state_q)
      S_FILL: if (accept && (fcnt_q == PRE_LAST)) begin
        fill_done = 1'b1;
        state_d   = S_ARM;
      end
      S_ARM: if (accept) begin
        // a level crossing on the timeout sample still counts as a level trigger
        if (lvl_hit) begin
          trig_ev = 1'b1;
        end else if (time_hit) begin
          trig_ev  = 1'b1;
          force_ev = 1'b1;
        end
        if (trig_ev) state_d = S_POST;
      end
      S_POST: if (accept && (pcnt_q == ONE_A)) begin
        post_done = 1'b1;
        state_d   = S_READY;
      end
      S_READY: if (smpl_bus.smpl_req && (rcnt_q != '0)) begin
        read_en = 1'b1;
        if (rcnt_q == ONE_R) begin
          read_last = 1'b1;
          state_d   = S_FILL;
        end
      end
      default: state_d = S_FILL;
    endcase
  end

  always_ff @(posedge clkSmpl) begin
    if (accept) mem[wp_q] <= adc;
  end

  always_ff @(posedge clkSmpl or negedge n_reset) begin
    if (!n_reset) begin
      wp_q    <= '0;
      rp_q    <= '0;
      ta_q    <= '0;
      fcnt_q  <= '0;
      pcnt_q  <= '0;
      rcnt_q  <= '0;
      tcnt_q  <= '0;
      prev_q  <= '0;
      smpl_q  <= '0;
      avail_q <= 1'b0;
      auto_q  <= 1'b0;
    end else begin
      if (accept) begin
        wp_q   <= wp_q + ONE_A;
        prev_q <= adc;
      end
      if (accept && (state_q == S_FILL)) fcnt_q <= fcnt_q + ONE_A;
      if (fill_done) begin
        fcnt_q <= '0;
        tcnt_q <= '0;
      end
      if (accept && (state_q == S_ARM)) begin
        if (trig_ev) begin
          ta_q   <= wp_q;
          pcnt_q <= PCNT_INIT;
          auto_q <= force_ev;
        end else begin
          tcnt_q <= tcnt_q + ONE_T;
        end
      end
      if (accept && (state_q == S_POST)) pcnt_q <= pcnt_q - ONE_A;
      if (post_done) begin
        rp_q    <= ta_q - PRE_OFS;
        rcnt_q  <= RCNT_INIT;
        avail_q <= 1'b1;
      end
      if (read_en) begin
        smpl_q <= mem[rp_q];
        rp_q   <= rp_q + ONE_A;
        rcnt_q <= rcnt_q - ONE_R;
      end
      if (read_last) begin
        avail_q <= 1'b0;
        prev_q  <= '0;
        fcnt_q  <= '0;
      end
    end
  end

  assign smpl_bus.smpl_avail = avail_q;
  assign smpl_bus.smpl       = smpl_q;
  assign auto_trig           = auto_q;

endmodule

// File: tb/tb_smpl_trigger_capture.sv
// Bench for smpl_trigger_capture: table of frame scenarios checked against a
// frame-level reference model, plus stall, no-timeout and reset-in-readout sequences.
module tb_smpl_trigger_capture;

  localparam int N    = 64;
  localparam int PRE  = 16;
  localparam int AUTO = 32;

  logic       clkSmpl = 1'b0;
  logic       n_reset = 1'b0;
  logic       adc_valid = 1'b0;
  logic [9:0] adc = '0;
  logic [9:0] trig_level = '0;
  logic       trig_fall = 1'b0;
  logic       trig_auto = 1'b0;
  logic       auto_trig;

  smpl_trigger_capture_if bus ();

  smpl_trigger_capture #(.N(N), .PRE(PRE), .AUTO(AUTO)) dut (
    .clkSmpl    (clkSmpl),
    .n_reset    (n_reset),
    .adc_valid  (adc_valid),
    .adc        (adc),
    .trig_level (trig_level),
    .trig_fall  (trig_fall),
    .trig_auto  (trig_auto),
    .auto_trig  (auto_trig),
    .smpl_bus   (bus)
  );

  always #5 clkSmpl = ~clkSmpl;

  // kind: 0 ramp (start + step*k), 1 constant, 2 random; -1 = no fixed expectation
  typedef struct {
    int kind;
    int start;
    int step;
    int level;
    bit fall;
    bit auto_en;
    bit stall;
    int exp_cnt;
    int exp_w0;
    int exp_w16;
    int exp_auto;
  } vec_t;

  vec_t tbl[6];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   acc[$];
  int   words[$];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Frame model: first Arm sample index (>= PRE) that crosses the level, or the
  // AUTO-th Arm sample when the timeout is enabled.
  function automatic int model_trig(input int lvl, input bit fall, input bit auto_en,
                                    output bit forced);
    forced = 1'b0;
    for (int i = PRE; i < acc.size(); i++) begin
      int p = acc[i-1];
      int a = acc[i];
      bit hit = fall ? (p > lvl && a <= lvl) : (p < lvl && a >= lvl);
      if (hit) return i;
      if (auto_en && (i - PRE) == AUTO - 1) begin
        forced = 1'b1;
        return i;
      end
    end
    return -1;
  endfunction

  task automatic do_reset();
    adc_valid = 1'b0;
    bus.smpl_req = 1'b0;
    n_reset = 1'b0;
    repeat (3) @(negedge clkSmpl);
    n_reset = 1'b1;
  endtask

  task automatic feed(input vec_t v, output int cnt);
    bit done = 1'b0;
    cnt = 0;
    acc.delete();
    trig_level = 10'(v.level);
    trig_fall  = v.fall;
    trig_auto  = v.auto_en;
    for (int cyc = 0; cyc < 2000 && !done; cyc++) begin
      @(negedge clkSmpl);
      if (bus.smpl_avail) begin
        done = 1'b1;
        adc_valid = 1'b0;
      end else if (v.kind == 2 && $urandom_range(0, 3) == 0) begin
        adc_valid = 1'b0;
        adc = 10'($urandom);
      end else begin
        int s;
        if (v.kind == 0)      s = v.start + v.step * cnt;
        else if (v.kind == 1) s = v.start;
        else                  s = int'($urandom_range(0, 1023));
        adc = 10'(s);
        adc_valid = 1'b1;
        acc.push_back(s);
        cnt++;
      end
    end
    if (!done) chk("avail_timeout", 0, 1);
  endtask

  task automatic drain(input bit stall, input int limit);
    bit req_d = 1'b1;
    int gap = 0;
    words.delete();
    bus.smpl_req = 1'b1;
    adc_valid = 1'b1;
    adc = 10'($urandom);
    for (int cyc = 0; cyc < 1000 && words.size() < limit; cyc++) begin
      @(negedge clkSmpl);
      if (req_d) begin
        words.push_back(int'(bus.smpl));
        chk("avail_while_reading", int'(bus.smpl_avail), (words.size() < N) ? 1 : 0);
      end else begin
        chk("avail_during_gap", int'(bus.smpl_avail), 1);
      end
      if (words.size() >= limit) begin
        req_d = 1'b0;
        adc_valid = 1'b0;
      end else begin
        if (stall && req_d && $urandom_range(0, 1) == 1) gap = $urandom_range(1, 3);
        if (gap > 0) begin
          req_d = 1'b0;
          gap--;
        end else begin
          req_d = 1'b1;
        end
        adc_valid = 1'b1;
        adc = 10'($urandom);
      end
      bus.smpl_req = req_d;
    end
    bus.smpl_req = 1'b0;
    if (words.size() < limit) chk("drain_timeout", words.size(), limit);
  endtask

  task automatic run_frame(input vec_t v_in, input int limit, input string tag);
    vec_t v = v_in;
    int   cnt, t, nbad;
    bit   forced;
    if (v.kind == 2) begin
      v.level = int'($urandom_range(0, 1023));
      v.fall  = 1'($urandom_range(0, 1));
    end
    feed(v, cnt);
    t = model_trig(v.level, v.fall, v.auto_en, forced);
    if (t < 0) begin
      chk({tag, "_model_trigger_found"}, 0, 1);
      return;
    end
    chk({tag, "_avail_after_samples"}, cnt, t + N - PRE);
    if (v.exp_cnt >= 0) chk({tag, "_avail_samples_fixed"}, cnt, v.exp_cnt);
    chk({tag, "_auto_trig"}, int'(auto_trig), int'(forced));
    if (v.exp_auto >= 0) chk({tag, "_auto_trig_fixed"}, int'(auto_trig), v.exp_auto);
    drain(v.stall, limit);
    chk({tag, "_word_count"}, words.size(), limit);
    nbad = 0;
    for (int i = 0; i < words.size(); i++) begin
      int k = t - PRE + i;
      if (k < 0 || k >= acc.size() || words[i] != (acc[k] & 1023)) nbad++;
    end
    chk({tag, "_frame_words_wrong"}, nbad, 0);
    if (words.size() == N) begin
      if (v.exp_w0 >= 0)  chk({tag, "_word0"}, words[0], v.exp_w0);
      if (v.exp_w16 >= 0) chk({tag, "_word16"}, words[PRE], v.exp_w16);
      if (v.kind == 0 && v.step < 0) begin
        nbad = 0;
        for (int i = 1; i < N; i++) if (words[i] >= words[i-1]) nbad++;
        chk({tag, "_not_decreasing"}, nbad, 0);
      end
    end
  endtask

  initial begin
    int seen;
    tbl[0] = '{0, 0,   4,  256, 1'b0, 1'b0, 1'b0, 112, 192, 256, 0};
    tbl[1] = '{0, 511, -4, 256, 1'b1, 1'b0, 1'b0, 112, 319, 255, 0};
    tbl[2] = '{1, 100, 0,  300, 1'b0, 1'b1, 1'b0, 95,  100, 100, 1};
    tbl[3] = '{2, 0,   0,  0,   1'b0, 1'b1, 1'b1, -1,  -1,  -1,  -1};
    tbl[4] = '{2, 0,   0,  0,   1'b0, 1'b1, 1'b1, -1,  -1,  -1,  -1};
    tbl[5] = '{2, 0,   0,  0,   1'b0, 1'b1, 1'b0, -1,  -1,  -1,  -1};

    bus.smpl_req = 1'b0;
    do_reset();
    @(negedge clkSmpl);
    chk("reset_avail", int'(bus.smpl_avail), 0);
    chk("reset_smpl", int'(bus.smpl), 0);
    chk("reset_auto_trig", int'(auto_trig), 0);

    for (int r = 0; r < 6; r++) run_frame(tbl[r], N, $sformatf("row%0d", r));

    // requests after the frame is drained are ignored and smpl holds
    bus.smpl_req = 1'b1;
    repeat (3) @(negedge clkSmpl);
    chk("post_drain_smpl_hold", int'(bus.smpl), words[N-1]);
    chk("post_drain_avail", int'(bus.smpl_avail), 0);
    bus.smpl_req = 1'b0;

    // no timeout: constant level below threshold never completes a frame
    do_reset();
    trig_level = 10'd300;
    trig_fall = 1'b0;
    trig_auto = 1'b0;
    adc = 10'd100;
    adc_valid = 1'b1;
    seen = 0;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clkSmpl);
      if (bus.smpl_avail) seen++;
    end
    chk("no_auto_avail_cycles", seen, 0);

    // reset while reading out, then a fresh frame with full pre-trigger fill
    do_reset();
    run_frame(tbl[0], 10, "partial");
    #2 n_reset = 1'b0;
    #1;
    chk("midread_reset_avail", int'(bus.smpl_avail), 0);
    chk("midread_reset_smpl", int'(bus.smpl), 0);
    @(negedge clkSmpl);
    n_reset = 1'b1;
    run_frame(tbl[0], N, "after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/smpl_trigger_capture.md
# smpl_trigger_capture

Triggered sample capture stage on the sample clock domain. Continuously writes ADC samples into a circular buffer, detects a level-crossing trigger (or forces one on auto-timeout), completes a frame of N samples centred PRE samples after the buffer start, then streams that frame to the sparse sample renderer over the smpl_avail / smpl_req / smpl handshake. After readout it re-arms for the next frame.

## Interface
- N, 64: frame length in samples; power of two, ≥ 4; must equal the renderer's SIZE.
- PRE, 16: pre-trigger samples per frame; 1 ≤ PRE ≤ N-2.
- AUTO, 4096: auto-trigger timeout, in accepted samples spent in Arm.
- clkSmpl  in  1  sample clock.
- n_reset  in  1  asynchronous, active-low reset.
- adc_valid  in  1  adc holds a new sample this cycle.
- adc  in  10  raw sample; bit 9 set = out of range.
- trig_level  in  10  trigger threshold; unsigned compare on all 10 bits.
- trig_fall  in  1  0 = rising-edge trigger, 1 = falling-edge trigger.
- trig_auto  in  1  enables the auto-trigger timeout.
- smpl_avail  out  1  a complete frame is ready for readout.
- smpl_req  in  1  consumer read request, level-sensitive.
- smpl  out  10  frame data word.
- auto_trig  out  1  last frame was force-triggered by timeout.

## Operation
- Buffer: N x 10 circular RAM. Write pointer wp advances mod N on each accepted sample. An accepted sample is adc_valid=1 in Fill, Arm or Post.
- prev: the previous accepted sample. It is cleared to 0 on entry to Fill.
- Trigger condition:
  - Rising (trig_fall=0): prev < trig_level && adc ≥ trig_level.
  - Falling (trig_fall=1): prev > trig_level && adc ≤ trig_level.
  - Only evaluated on accepted samples in Arm.
- States:
  - Fill: accept samples; count PRE accepted samples, then go to Arm. Guarantees valid pre-trigger history.
  - Arm: accept samples and count timeout tcnt.
    - If the trigger condition holds: the trigger sample is written at address ta = wp. Go to Post with pcnt = N-PRE-1.
    - Else if trig_auto && tcnt == AUTO-1: force trigger on this sample the same way and set auto_trig.
  - Post: accept samples, decrementing pcnt. When pcnt reaches 0, go to Ready.
    - rp = ta - PRE (mod N).
    - rcnt = N.
    - smpl_avail = 1.
  - Ready: ADC input is ignored. On each clkSmpl edge with smpl_req=1 and rcnt ≠ 0:
    - smpl ← RAM[rp], rp++, rcnt--.
    - When rcnt reaches 0, smpl_avail drops and the state goes to Fill.
    - smpl_req while rcnt = 0 is ignored; smpl holds its last value.
- Frame ordering: the frame is read oldest first. Word index PRE is the trigger sample.
- auto_trig: updated at each trigger event. It is 0 for a level trigger and 1 for a forced trigger. It holds until the next trigger.

## Timing
- Reset values: smpl_avail=0, smpl=0, auto_trig=0, state=Fill, all pointers and counters 0, prev=0.
- Reset mid-readout aborts the frame immediately.
- Write latency: a sample accepted at edge k is readable from RAM at edge k+1.
- Readout handshake:
  - smpl_req sampled high at edge k → smpl valid after edge k.
  - The consumer registers smpl_req and writes smpl at edge k+1. This matches its one-cycle-delayed write enable.
  - smpl_req may drop for any number of cycles mid-frame; rp and rcnt hold.
- Ready-to-avail: smpl_avail rises at the same edge that consumes the last Post sample.
- smpl_avail falls at the edge delivering word N-1.
- Fill begins on the following cycle.
- A trigger on the sample that also reaches the timeout counts as a level trigger (auto_trig=0).
- adc_valid during Ready is dropped. No overrun flag.
- Width: tcnt is ceil(log2(AUTO)) bits. Pointers are log2(N) bits and wrap naturally.

## Test plan
- Rising trigger: N=64, PRE=16, trig_level=256, ramp 0..511 step 4 with adc_valid=1. Drain with smpl_req held high. Required:
  - 64 words are delivered.
  - Word 16 is 256.
  - Word 0 is 192.
  - auto_trig=0.
- Falling trigger: trig_fall=1, descending ramp 511..0 step 4, trig_level=256. Required:
  - Word 16 is the first value ≤ 256.
  - Words are strictly decreasing.
- Auto trigger: constant adc=100, trig_level=300, trig_auto=1, AUTO=32. Required:
  - smpl_avail rises 16 + 32 + 47 accepted samples after reset.
  - auto_trig=1.
  - All 64 words are 100.
- No auto: the same stimulus with trig_auto=0 for 10000 cycles. Required: smpl_avail stays 0.
- Stalled readout: toggle smpl_req randomly, 1-3 cycle gaps. Required:
  - The delivered sequence is identical to an unstalled run.
  - smpl_avail drops after exactly 64 requested edges.
  - A second frame follows.
- Reset in Ready: assert n_reset after 10 words are read. Required:
  - smpl_avail=0 and smpl=0 immediately.
  - The next frame starts with a full PRE fill.
